// File: rtl/rv_decode_pipe.sv
// RV32I(+M, +Zicsr) decode stage: combinational decode of the fetched word, captured into a
// two-entry main/skid buffer and presented downstream with valid/ready.
module rv_decode_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_M   = 1'b1,
  parameter bit          ENABLE_CSR = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_reg_write,
  output logic             out_mem_to_reg,
  output logic             out_mem_write,
  output logic             out_mem_read,
  output logic             out_alu_src,
  output logic             out_branch,
  output logic             out_jump,
  output logic [4:0]       out_alu_op,
  output logic [11:0]      out_csr_addr,
  output logic             out_csr_we,
  output logic [1:0]       out_csr_op,
  output logic             out_csr_imm_sel,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_write;
    logic            mem_read;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [4:0]      alu_op;
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic [1:0]      csr_op;
    logic            csr_imm_sel;
    logic            illegal;
  } entry_t;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1;
  entry_t     dec;
  logic       legal;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rs1    = in_instr[19:15];

  always_comb begin
    dec       = '0;
    dec.instr = in_instr;
    dec.pc    = in_pc;
    legal     = 1'b1;
    case (opcode)
      7'b0110111: begin // LUI
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 5'h0A;
      end
      7'b0010111: begin // AUIPC
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 5'h00;
      end
      7'b1101111: begin // JAL
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_op = 5'h0A;
      end
      7'b1100111: begin // JALR
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 5'h00;
        legal = (funct3 == 3'b000);
      end
      7'b1100011: begin
        dec.branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec.alu_op = 5'h01;
          3'b100:         dec.alu_op = 5'h02;
          3'b110:         dec.alu_op = 5'h03;
          3'b101, 3'b111: dec.alu_op = 5'h0B;
          default:        legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; dec.mem_read = 1'b1; dec.alu_src = 1'b1;
        legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      7'b0100011: begin
        dec.mem_write = 1'b1; dec.alu_src = 1'b1;
        legal = (funct3 inside {3'b000, 3'b001, 3'b010});
      end
      7'b0010011: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        case (funct3)
          3'b000: dec.alu_op = 5'h00;
          3'b010: dec.alu_op = 5'h02;
          3'b011: dec.alu_op = 5'h03;
          3'b100: dec.alu_op = 5'h05;
          3'b110: dec.alu_op = 5'h08;
          3'b111: dec.alu_op = 5'h09;
          3'b001: begin dec.alu_op = 5'h04; legal = (funct7 == 7'b0000000); end
          default: begin
            dec.alu_op = (funct7 == 7'b0100000) ? 5'h07 : 5'h06;
            legal      = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      7'b0110011: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.alu_op = 5'h00;
            3'b001:  dec.alu_op = 5'h04;
            3'b010:  dec.alu_op = 5'h02;
            3'b011:  dec.alu_op = 5'h03;
            3'b100:  dec.alu_op = 5'h05;
            3'b101:  dec.alu_op = 5'h06;
            3'b110:  dec.alu_op = 5'h08;
            default: dec.alu_op = 5'h09;
          endcase
        end else if (funct7 == 7'b0100000) begin
          dec.alu_op = (funct3 == 3'b000) ? 5'h01 : 5'h07;
          legal      = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else if (funct7 == 7'b0000001 && ENABLE_M) begin
          dec.alu_op = {2'b10, funct3};
        end else begin
          legal = 1'b0;
        end
      end
      7'b0001111: dec.alu_op = 5'h0A;
      7'b1110011: begin
        dec.alu_op = 5'h0A;
        if (funct3 != 3'b000) begin
          // csr_we is dropped for set/clear with a zero source: pure read, no side effect.
          dec.reg_write   = 1'b1;
          dec.csr_addr    = in_instr[31:20];
          dec.csr_op      = 2'(funct3[1:0] - 2'd1);
          dec.csr_imm_sel = funct3[2];
          dec.csr_we      = (funct3[1:0] == 2'b01) || (rs1 != 5'd0);
          legal           = ENABLE_CSR && (funct3 != 3'b100);
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.instr   = in_instr;
      dec.pc      = in_pc;
      dec.alu_op  = 5'h0F;
      dec.illegal = 1'b1;
    end
  end

  entry_t           main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept, transfer;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q && !flush;
  assign transfer = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    count_d      = count_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || transfer) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    if (transfer && main_q.illegal && !flush && count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      count_q      <= count_d;
    end
  end

  assign out_valid       = main_valid_q;
  assign out_instr       = main_q.instr;
  assign out_pc          = main_q.pc;
  assign out_reg_write   = main_q.reg_write;
  assign out_mem_to_reg  = main_q.mem_to_reg;
  assign out_mem_write   = main_q.mem_write;
  assign out_mem_read    = main_q.mem_read;
  assign out_alu_src     = main_q.alu_src;
  assign out_branch      = main_q.branch;
  assign out_jump        = main_q.jump;
  assign out_alu_op      = main_q.alu_op;
  assign out_csr_addr    = main_q.csr_addr;
  assign out_csr_we      = main_q.csr_we;
  assign out_csr_op      = main_q.csr_op;
  assign out_csr_imm_sel = main_q.csr_imm_sel;
  assign out_illegal     = main_q.illegal;
  assign illegal_count   = count_q;

endmodule

// File: tb/tb_rv_decode_pipe.sv
// Directed bench for rv_decode_pipe: a default instance (A) and an ENABLE_M=0, CNT_W=2
// instance (B) share all inputs.
module tb_rv_decode_pipe;

  logic        clk, rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_out_valid, a_reg_write, a_mem_to_reg, a_mem_write, a_mem_read;
  logic        a_alu_src, a_branch, a_jump, a_csr_we, a_csr_imm_sel, a_illegal;
  logic [31:0] a_instr, a_pc;
  logic [4:0]  a_alu_op;
  logic [11:0] a_csr_addr;
  logic [1:0]  a_csr_op;
  logic [15:0] a_count;

  logic        b_in_ready, b_out_valid, b_reg_write, b_mem_to_reg, b_mem_write, b_mem_read;
  logic        b_alu_src, b_branch, b_jump, b_csr_we, b_csr_imm_sel, b_illegal;
  logic [31:0] b_instr, b_pc;
  logic [4:0]  b_alu_op;
  logic [11:0] b_csr_addr;
  logic [1:0]  b_csr_op;
  logic [1:0]  b_count;

  int tests = 0;
  int fails = 0;

  rv_decode_pipe dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_instr), .out_pc(a_pc), .out_reg_write(a_reg_write),
    .out_mem_to_reg(a_mem_to_reg), .out_mem_write(a_mem_write), .out_mem_read(a_mem_read),
    .out_alu_src(a_alu_src), .out_branch(a_branch), .out_jump(a_jump), .out_alu_op(a_alu_op),
    .out_csr_addr(a_csr_addr), .out_csr_we(a_csr_we), .out_csr_op(a_csr_op),
    .out_csr_imm_sel(a_csr_imm_sel), .out_illegal(a_illegal), .illegal_count(a_count)
  );

  rv_decode_pipe #(.ENABLE_M(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_instr), .out_pc(b_pc), .out_reg_write(b_reg_write),
    .out_mem_to_reg(b_mem_to_reg), .out_mem_write(b_mem_write), .out_mem_read(b_mem_read),
    .out_alu_src(b_alu_src), .out_branch(b_branch), .out_jump(b_jump), .out_alu_op(b_alu_op),
    .out_csr_addr(b_csr_addr), .out_csr_we(b_csr_we), .out_csr_op(b_csr_op),
    .out_csr_imm_sel(b_csr_imm_sel), .out_illegal(b_illegal), .illegal_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    chk("reset out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("reset count", {16'd0, a_count}, 32'd0);
    chk("reset alu_op", {27'd0, a_alu_op}, 32'd0);
    chk("reset ctrl", {25'd0, a_reg_write, a_mem_to_reg, a_mem_write, a_mem_read, a_alu_src,
                       a_branch, a_jump}, 32'd0);
  endtask

  task automatic test_addi;
    do_reset;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
    step;
    in_valid = 1'b0;
    chk("addi out_valid", {31'd0, a_out_valid}, 32'd1);
    chk("addi alu_op", {27'd0, a_alu_op}, 32'h00);
    chk("addi alu_src", {31'd0, a_alu_src}, 32'd1);
    chk("addi reg_write", {31'd0, a_reg_write}, 32'd1);
    chk("addi pc", a_pc, 32'h100);
    step;
    chk("addi drained", {31'd0, a_out_valid}, 32'd0);
  endtask

  task automatic test_skid;
    do_reset;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h10;
    step;
    chk("skid in_ready after 1", {31'd0, a_in_ready}, 32'd1);
    in_instr = 32'h00200113; in_pc = 32'h14;
    step;
    chk("skid in_ready after 2", {31'd0, a_in_ready}, 32'd0);
    in_instr = 32'h00300193; in_pc = 32'h18;
    step;
    in_valid = 1'b0;
    chk("skid head instr", a_instr, 32'h00100093);
    chk("skid head valid", {31'd0, a_out_valid}, 32'd1);
    out_ready = 1'b1;
    step;
    chk("skid second instr", a_instr, 32'h00200113);
    chk("skid second pc", a_pc, 32'h14);
    chk("skid in_ready back", {31'd0, a_in_ready}, 32'd1);
    step;
    chk("skid third dropped", {31'd0, a_out_valid}, 32'd0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] ins [8] = '{32'h40B50533, 32'h00B55463, 32'h00B52023, 32'h00052503,
                             32'h02151513, 32'h40155513, 32'h00000073, 32'h000000EF};
    logic [4:0]  ops [8] = '{5'h01, 5'h0B, 5'h00, 5'h00, 5'h0F, 5'h07, 5'h0A, 5'h0A};
    logic [6:0]  flg [8] = '{7'b1000000, 7'b0000010, 7'b0010100, 7'b1101100,
                             7'b0000000, 7'b1000100, 7'b0000000, 7'b1000001};
    logic        ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_instr = ins[i]; in_pc = 32'h200 + 32'(4 * i);
      step;
      chk($sformatf("b2b[%0d] valid", i), {31'd0, a_out_valid}, 32'd1);
      chk($sformatf("b2b[%0d] pc", i), a_pc, 32'h200 + 32'(4 * i));
      chk($sformatf("b2b[%0d] alu_op", i), {27'd0, a_alu_op}, {27'd0, ops[i]});
      chk($sformatf("b2b[%0d] flags", i), {25'd0, a_reg_write, a_mem_to_reg, a_mem_write,
          a_mem_read, a_alu_src, a_branch, a_jump}, {25'd0, flg[i]});
      chk($sformatf("b2b[%0d] illegal", i), {31'd0, a_illegal}, {31'd0, ill[i]});
      chk($sformatf("b2b[%0d] in_ready", i), {31'd0, a_in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step;
    chk("b2b slli count", {16'd0, a_count}, 32'd1);
  endtask

  task automatic test_mul;
    do_reset;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h02B50533;
    step;
    in_valid = 1'b0;
    chk("mul a alu_op", {27'd0, a_alu_op}, 32'h10);
    chk("mul a illegal", {31'd0, a_illegal}, 32'd0);
    chk("mul b illegal", {31'd0, b_illegal}, 32'd1);
    chk("mul b alu_op", {27'd0, b_alu_op}, 32'h0F);
    chk("mul b reg_write", {31'd0, b_reg_write}, 32'd0);
    step;
    chk("mul b count", {30'd0, b_count}, 32'd1);
    chk("mul a count", {16'd0, a_count}, 32'd0);
  endtask

  task automatic test_csr;
    do_reset;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h300022F3;
    step;
    chk("csrrs x0 addr", {20'd0, a_csr_addr}, 32'h300);
    chk("csrrs x0 we", {31'd0, a_csr_we}, 32'd0);
    chk("csrrs x0 reg_write", {31'd0, a_reg_write}, 32'd1);
    chk("csrrs x0 op", {30'd0, a_csr_op}, 32'd1);
    in_instr = 32'h3000A2F3;
    step;
    chk("csrrs x1 we", {31'd0, a_csr_we}, 32'd1);
    chk("csrrs x1 imm_sel", {31'd0, a_csr_imm_sel}, 32'd0);
    in_instr = 32'h300052F3;
    step;
    in_valid = 1'b0;
    chk("csrrwi we", {31'd0, a_csr_we}, 32'd1);
    chk("csrrwi imm_sel", {31'd0, a_csr_imm_sel}, 32'd1);
    chk("csrrwi op", {30'd0, a_csr_op}, 32'd0);
  endtask

  task automatic test_flush;
    do_reset;
    in_valid = 1'b1; in_instr = 32'h00100093;
    step;
    in_instr = 32'h00200113;
    step;
    chk("flush pre full", {31'd0, a_in_ready}, 32'd0);
    in_instr = 32'h00300193; flush = 1'b1;
    step;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, a_in_ready}, 32'd1);
    out_ready = 1'b1;
    step;
    chk("flush nothing accepted", {31'd0, a_out_valid}, 32'd0);
  endtask

  task automatic test_saturate;
    logic [1:0] exp_cnt [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) in_valid = 1'b0;
      step;
      if (k >= 2) chk($sformatf("sat count step %0d", k), {30'd0, b_count}, {30'd0, exp_cnt[k]});
    end
    chk("sat wide count", {16'd0, a_count}, 32'd5);
    in_valid = 1'b1;
    step;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst b count", {30'd0, b_count}, 32'd0);
    chk("async rst a count", {16'd0, a_count}, 32'd0);
    chk("async rst out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("async rst in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("async rst illegal", {31'd0, a_illegal}, 32'd0);
    chk("async rst alu_op", {27'd0, a_alu_op}, 32'd0);
    in_valid = 1'b0;
    step;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    test_reset;
    test_addi;
    test_skid;
    test_back_to_back;
    test_mul;
    test_csr;
    test_flush;
    test_saturate;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
